// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state encoding and the
// oversample-ratio legality check used by both the receiver and transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // The 3-sample vote sits at M-1..M+1, so the ratio must be even and leave room around M.
    function automatic bit oversample_ok(input int os);
        return (os >= 4) && ((os % 2) == 0);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input pin, with a configurable
// reset value so an idle-high line does not look like activity out of reset.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receive stage: start-bit validation, LSB-first shift-in,
// parity/stop checking and a one-entry valid/ready output slot.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = PARITY_NONE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxTick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] outData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 frameError,
    output logic                 parityError,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int M   = OVERSAMPLE / 2;

    localparam logic [SCW-1:0] SC_ONE    = SCW'(1);
    localparam logic [SCW-1:0] SC_LAST   = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] SC_VOTE_A = SCW'(M - 1);
    localparam logic [SCW-1:0] SC_VOTE_B = SCW'(M);
    localparam logic [SCW-1:0] SC_VOTE_C = SCW'(M + 1);
    localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

    if (!oversample_ok(OVERSAMPLE)) begin : g_bad_oversample
        $error("uart_receiver: OVERSAMPLE must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_receiver: DATA_BITS must be in 5..9");
    end

    logic                 rx_s;
    rx_state_e            state_q;
    logic                 armed_q;
    logic [SCW-1:0]       sc_q;
    logic [BCW-1:0]       bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [1:0]           samp_q;
    logic                 par_q;
    logic [DATA_BITS-1:0] out_data_q;
    logic                 out_valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 overrun_q;

    logic vote;
    logic at_vote;
    logic par_err_d;

    uart_sync #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        par_err_d = 1'b0;
        vote      = (samp_q[0] & samp_q[1]) | (rx_s & (samp_q[0] | samp_q[1]));
        at_vote   = (sc_q == SC_VOTE_C);
        if (PARITY == PARITY_ODD) begin
            par_err_d = ~(^shift_q ^ par_q);
        end else if (PARITY == PARITY_EVEN) begin
            par_err_d = ^shift_q ^ par_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            sc_q         <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            samp_q       <= '0;
            par_q        <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (out_valid_q && outReady) begin
                out_valid_q <= 1'b0;
            end

            if (rxTick) begin
                if (sc_q == SC_VOTE_A) samp_q[0] <= rx_s;
                if (sc_q == SC_VOTE_B) samp_q[1] <= rx_s;
                sc_q <= sc_q + SC_ONE;

                unique case (state_q)
                    ST_IDLE: begin
                        sc_q <= '0;
                        if (rx_s) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            // The detecting tick is sample 0 of the start bit.
                            state_q <= ST_START;
                            armed_q <= 1'b0;
                            sc_q    <= SC_ONE;
                        end
                    end
                    ST_START: begin
                        if (at_vote && vote) begin
                            state_q <= ST_IDLE;
                            sc_q    <= '0;
                        end else if (sc_q == SC_LAST) begin
                            state_q <= ST_DATA;
                            sc_q    <= '0;
                            bit_q   <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (at_vote) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                        if (sc_q == SC_LAST) begin
                            sc_q  <= '0;
                            bit_q <= bit_q + BIT_ONE;
                            if (bit_q == BIT_LAST) begin
                                state_q <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (at_vote) par_q <= vote;
                        if (sc_q == SC_LAST) begin
                            sc_q    <= '0;
                            state_q <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        // Return to IDLE mid stop bit so the next start edge is never missed.
                        if (at_vote) begin
                            state_q <= ST_IDLE;
                            sc_q    <= '0;
                            if (!out_valid_q || outReady) begin
                                out_data_q   <= shift_q;
                                out_valid_q  <= 1'b1;
                                frame_err_q  <= ~vote;
                                parity_err_q <= par_err_d;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign outData     = out_data_q;
    assign outValid    = out_valid_q;
    assign frameError  = frame_err_q;
    assign parityError = parity_err_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
